// File: rtl/video_stream_gen.sv
// Synthetic pixel-stream source: programmable frame/line timing with selectable
// test patterns, driving VSYNC/HSYNC/EN/Data toward the preprocessing ASIC input.
module video_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_GAP    = 16,
  parameter int V_LEAD   = 8,
  parameter int V_TAIL   = 8,
  parameter int F_GAP    = 32,
  parameter int CW       = 16
) (
  input  logic       clk_sys,
  input  logic       reset_sys,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] frame_num,
  input  logic [1:0] pat_sel,
  input  logic [7:0] pat_val,
  output logic       OutVSYNC,
  output logic       OutHSYNC,
  output logic       OutEN,
  output logic [7:0] OutData,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_V_LEAD,
    ST_LINE,
    ST_H_GAP,
    ST_V_TAIL,
    ST_F_GAP
  } state_t;

  localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HG_LAST = CW'(H_GAP - 1);
  localparam logic [CW-1:0] VL_LAST = CW'(V_LEAD - 1);
  localparam logic [CW-1:0] VT_LAST = CW'(V_TAIL - 1);
  localparam logic [CW-1:0] FG_LAST = CW'(F_GAP - 1);

  state_t        state;
  logic [CW-1:0] x, y, cnt;
  logic [7:0]    num_lat, val_lat;
  logic [1:0]    sel_lat;
  logic          stop_flag;
  logic          stop_hit;
  logic [7:0]    next_cnt;

  function automatic logic [7:0] pattern(input logic [CW-1:0] px, input logic [CW-1:0] py,
                                         input logic [1:0] sel, input logic [7:0] val);
    case (sel)
      2'd0:    pattern = px[7:0];
      2'd1:    pattern = py[7:0];
      2'd2:    pattern = (px[3] ^ py[3]) ? 8'hFF : 8'h00;
      default: pattern = val;
    endcase
  endfunction

  // A stop seen on the deciding edge itself counts as well as an earlier sticky one
  assign stop_hit = stop_flag | stop;
  assign next_cnt = frame_cnt + 8'd1;

  // Outputs are loaded with the values of the state being entered, so they are registered
  always_ff @(posedge clk_sys or negedge reset_sys) begin
    if (!reset_sys) begin
      state      <= ST_IDLE;
      x          <= '0;
      y          <= '0;
      cnt        <= '0;
      num_lat    <= '0;
      sel_lat    <= '0;
      val_lat    <= '0;
      stop_flag  <= 1'b0;
      OutVSYNC   <= 1'b0;
      OutHSYNC   <= 1'b0;
      OutEN      <= 1'b0;
      OutData    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state != ST_IDLE && stop) stop_flag <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_lat   <= frame_num;
            sel_lat   <= pat_sel;
            val_lat   <= pat_val;
            frame_cnt <= '0;
            cnt       <= '0;
            OutVSYNC  <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_V_LEAD;
          end
        end
        ST_V_LEAD: begin
          if (cnt == VL_LAST) begin
            x        <= '0;
            y        <= '0;
            OutHSYNC <= 1'b1;
            OutEN    <= 1'b1;
            OutData  <= pattern('0, '0, sel_lat, val_lat);
            state    <= ST_LINE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LINE: begin
          if (x == H_LAST) begin
            OutHSYNC <= 1'b0;
            OutEN    <= 1'b0;
            OutData  <= '0;
            cnt      <= '0;
            state    <= (y == V_LAST) ? ST_V_TAIL : ST_H_GAP;
          end else begin
            x       <= x + 1'b1;
            OutData <= pattern(x + 1'b1, y, sel_lat, val_lat);
          end
        end
        ST_H_GAP: begin
          if (cnt == HG_LAST) begin
            x        <= '0;
            y        <= y + 1'b1;
            OutHSYNC <= 1'b1;
            OutEN    <= 1'b1;
            OutData  <= pattern('0, y + 1'b1, sel_lat, val_lat);
            state    <= ST_LINE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_V_TAIL: begin
          if (cnt == VT_LAST) begin
            OutVSYNC   <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= next_cnt;
            cnt        <= '0;
            if (stop_hit || (num_lat != 8'd0 && next_cnt == num_lat)) begin
              busy      <= 1'b0;
              stop_flag <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              state <= ST_F_GAP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_F_GAP: begin
          if (cnt == FG_LAST) begin
            cnt <= '0;
            if (stop_hit) begin
              busy      <= 1'b0;
              stop_flag <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              sel_lat  <= pat_sel;
              val_lat  <= pat_val;
              OutVSYNC <= 1'b1;
              state    <= ST_V_LEAD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen: randomized sequences compared cycle by
// cycle against an arithmetic model of frame timing and pattern content.
module tb_video_stream_gen;

  localparam int HA = 4;
  localparam int VA = 3;
  localparam int HG = 2;
  localparam int VL = 3;
  localparam int VT = 2;
  localparam int FG = 5;
  localparam int HC = 16;
  localparam int VC = 9;

  logic       clk_sys = 1'b0;
  logic       reset_sys;
  logic       start, start_c, stop;
  logic [7:0] frame_num, pat_val;
  logic [1:0] pat_sel;
  logic       vsync, hsync, en, busy, done;
  logic [7:0] data, fcnt;
  logic       vsync_c, hsync_c, en_c, busy_c, done_c;
  logic [7:0] data_c, fcnt_c;

  int checks = 0;
  int fails  = 0;

  always #5 clk_sys = ~clk_sys;

  video_stream_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_GAP(HG), .V_LEAD(VL),
                     .V_TAIL(VT), .F_GAP(FG), .CW(16)) dut (
    .clk_sys(clk_sys), .reset_sys(reset_sys), .start(start), .stop(stop),
    .frame_num(frame_num), .pat_sel(pat_sel), .pat_val(pat_val),
    .OutVSYNC(vsync), .OutHSYNC(hsync), .OutEN(en), .OutData(data),
    .busy(busy), .frame_done(done), .frame_cnt(fcnt));

  // Larger geometry so the checker pattern actually toggles on x[3] and y[3]
  video_stream_gen #(.H_ACTIVE(HC), .V_ACTIVE(VC), .H_GAP(HG), .V_LEAD(VL),
                     .V_TAIL(VT), .F_GAP(FG), .CW(16)) dut_c (
    .clk_sys(clk_sys), .reset_sys(reset_sys), .start(start_c), .stop(stop),
    .frame_num(frame_num), .pat_sel(pat_sel), .pat_val(pat_val),
    .OutVSYNC(vsync_c), .OutHSYNC(hsync_c), .OutEN(en_c), .OutData(data_c),
    .busy(busy_c), .frame_done(done_c), .frame_cnt(fcnt_c));

  task automatic checkOutput(input string tag, input logic [20:0] actual, input logic [20:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [20:0] getObs(input bit dsel);
    if (dsel) return {busy_c, done_c, vsync_c, hsync_c, en_c, fcnt_c, data_c};
    return {busy, done, vsync, hsync, en, fcnt, data};
  endfunction

  function automatic logic [20:0] pack(input logic b, input logic dn, input logic vs,
                                       input logic hs, input int cnt, input logic [7:0] d);
    return {b, dn, vs, hs, hs, 8'(cnt), d};
  endfunction

  function automatic logic [7:0] patRef(input int sel, input logic [7:0] val, input int px, input int py);
    case (sel)
      0:       return 8'(px % 256);
      1:       return 8'(py % 256);
      2:       return (((px / 8) + (py / 8)) % 2 == 1) ? 8'hFF : 8'h00;
      default: return val;
    endcase
  endfunction

  // Expected outputs at cycle t of a frame (t=0 is the first VSYNC-high cycle)
  function automatic logic [20:0] expFrame(input int t, input int h, input int v, input int sel,
                                           input logic [7:0] val, input int cnt);
    int u, line, pos;
    logic hs;
    logic [7:0] d;
    hs = 1'b0;
    d  = 8'h00;
    if (t >= VL && t < VL + v * h + (v - 1) * HG) begin
      u    = t - VL;
      line = u / (h + HG);
      pos  = u % (h + HG);
      if (pos < h) begin
        hs = 1'b1;
        d  = patRef(sel, val, pos, line);
      end
    end
    return pack(1'b1, 1'b0, 1'b1, hs, cnt, d);
  endfunction

  task automatic applyStimulus(input bit dsel, input string name, input int fnum, input int initSel,
                               input logic [7:0] initVal, input int chgSel, input logic [7:0] chgVal,
                               input int stopFrame, input int stopAt, input bit stopWithStart);
    int h, v, flen, curSel, frameSel;
    logic [7:0] curVal, frameVal;
    bit endAfter, endInGap;
    h = dsel ? HC : HA;
    v = dsel ? VC : VA;
    flen = VL + v * h + (v - 1) * HG + VT;
    frame_num = 8'(fnum);
    pat_sel = 2'(initSel);
    pat_val = initVal;
    curSel = initSel;
    curVal = initVal;
    if (dsel) start_c = 1'b1; else start = 1'b1;
    stop = stopWithStart;
    @(negedge clk_sys);
    start = 1'b0; start_c = 1'b0; stop = 1'b0;
    for (int f = 1; f <= 20; f++) begin
      frameSel = curSel;
      frameVal = curVal;
      for (int t = 0; t < flen; t++) begin
        checkOutput($sformatf("%s f%0d t%0d", name, f, t), getObs(dsel),
                    expFrame(t, h, v, frameSel, frameVal, f - 1));
        start = 1'b0; start_c = 1'b0; stop = 1'b0;
        if (f == 1 && t == 4) begin
          if (dsel) start_c = 1'b1; else start = 1'b1;
        end
        if (t == flen / 2 && chgSel >= 0) begin
          if (chgSel == 4) begin
            curSel = int'($urandom_range(0, 3));
            curVal = 8'($urandom);
          end else begin
            curSel = chgSel;
            curVal = chgVal;
          end
          pat_sel = 2'(curSel);
          pat_val = curVal;
        end
        if (f == stopFrame && t == stopAt) stop = 1'b1;
        @(negedge clk_sys);
      end
      start = 1'b0; start_c = 1'b0; stop = 1'b0;
      endAfter = (fnum != 0 && f == fnum) || (f == stopFrame && stopAt < flen);
      endInGap = (f == stopFrame && stopAt >= flen);
      if (endAfter) begin
        checkOutput($sformatf("%s f%0d done", name, f), getObs(dsel), pack(1'b0, 1'b1, 1'b0, 1'b0, f, 8'h00));
        @(negedge clk_sys);
        checkOutput($sformatf("%s f%0d idle", name, f), getObs(dsel), pack(1'b0, 1'b0, 1'b0, 1'b0, f, 8'h00));
        break;
      end
      for (int g = 0; g < FG; g++) begin
        checkOutput($sformatf("%s f%0d gap%0d", name, f, g), getObs(dsel),
                    pack(1'b1, g == 0, 1'b0, 1'b0, f, 8'h00));
        stop = 1'b0;
        if (endInGap && g == stopAt - flen) stop = 1'b1;
        @(negedge clk_sys);
      end
      stop = 1'b0;
      if (endInGap) begin
        checkOutput($sformatf("%s f%0d gapstop", name, f), getObs(dsel), pack(1'b0, 1'b0, 1'b0, 1'b0, f, 8'h00));
        @(negedge clk_sys);
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    reset_sys = 1'b0;
    start = 1'b0; start_c = 1'b0; stop = 1'b0;
    frame_num = 8'd0; pat_sel = 2'd0; pat_val = 8'd0;
    repeat (2) @(negedge clk_sys);
    checkOutput("reset main", getObs(1'b0), 21'd0);
    checkOutput("reset chk", getObs(1'b1), 21'd0);
    reset_sys = 1'b1;
    @(negedge clk_sys);
    stop = 1'b1;
    @(negedge clk_sys);
    stop = 1'b0;
    checkOutput("idle stop ignored", getObs(1'b0), 21'd0);

    applyStimulus(1'b0, "single", 1, 0, 8'h00, -1, 8'h00, 0, 0, 1'b0);
    applyStimulus(1'b0, "switch", 2, 0, 8'h00, 3, 8'hA5, 0, 0, 1'b0);
    applyStimulus(1'b0, "contstop", 0, 0, 8'h00, 4, 8'h00, 3, VL + (HA + HG) + 1, 1'b0);
    applyStimulus(1'b0, "yramp", 1, 1, 8'h00, -1, 8'h00, 0, 0, 1'b0);
    applyStimulus(1'b1, "checker", 1, 2, 8'h00, -1, 8'h00, 0, 0, 1'b0);
    applyStimulus(1'b0, "startstop", 1, 3, 8'h3C, -1, 8'h00, 0, 0, 1'b1);
    applyStimulus(1'b0, "gapstop", 0, 0, 8'h00, -1, 8'h00, 1, 21 + 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, $sformatf("rand%0d", i), int'($urandom_range(1, 3)),
                    int'($urandom_range(0, 3)), 8'($urandom), 4, 8'h00, 0, 0, 1'b0);
    end

    frame_num = 8'd1; pat_sel = 2'd3; pat_val = 8'h77;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    waited = 0;
    while (!hsync && waited < 50) begin
      @(negedge clk_sys);
      waited++;
    end
    checkOutput("line reached", {20'd0, hsync}, 21'd1);
    #2 reset_sys = 1'b0;
    #1 checkOutput("async reset midline", getObs(1'b0), 21'd0);
    @(negedge clk_sys);
    reset_sys = 1'b1;
    @(negedge clk_sys);
    checkOutput("idle after reset", getObs(1'b0), 21'd0);
    applyStimulus(1'b0, "after_reset", 1, 2, 8'h00, -1, 8'h00, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
